// File: rtl/dmm_defs.sv
// Shared encodings for the DMM converter blocks.
// The modulation sequencer and the MCU readout use the same values.
package dmm_defs;

    localparam int unsigned CLK_FREQ = 20_000_000;

    localparam logic [1:0] REFMUX_OFF = 2'b00;
    localparam logic [1:0] REFMUX_POS = 2'b01;
    localparam logic [1:0] REFMUX_NEG = 2'b10;

    localparam logic SW_INT_RESET_CLOSED = 1'b1;
    localparam logic SW_INT_RESET_OPEN   = 1'b0;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RESET_INT = 3'd1;
    localparam logic [2:0] ST_RUNUP     = 3'd2;
    localparam logic [2:0] ST_RUNDOWN   = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// Reusable for any slow asynchronous status line.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adc_multislope.sv
// Multi-slope integrating ADC sequencer: integrator reset, modulated
// run-up, timed run-down, result publish with a valid flag.
module adc_multislope
    import dmm_defs::*;
#(
    parameter int INT_RESET_N = 200,
    parameter int CYCLE_N     = 100,
    parameter int RUNDOWN_MAX = 4000,
    parameter int CW          = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adc_measure_trig,
    input  logic [31:0]   clk_count_aperture_n,
    input  logic          cmpr_in,
    output logic          adc_measure_valid,
    output logic          sw_int_reset,
    output logic [1:0]    refmux,
    output logic [CW-1:0] count_up,
    output logic [CW-1:0] count_down,
    output logic [CW-1:0] count_rundown,
    output logic          overflow,
    output logic [1:0]    monitor
);

    localparam logic [15:0]   RST_LAST = 16'(INT_RESET_N - 1);
    localparam logic [15:0]   CYC_LAST = 16'(CYCLE_N - 1);
    localparam logic [CW-1:0] RD_MAX   = CW'(RUNDOWN_MAX);
    localparam logic [CW-1:0] RD_LAST  = CW'(RUNDOWN_MAX - 1);

    logic          cmpr;
    logic [2:0]    state_q, state_d;
    logic          valid_q, valid_d;
    logic [1:0]    refmux_q, refmux_d;
    logic [CW-1:0] cnt_up_q, cnt_up_d;
    logic [CW-1:0] cnt_dn_q, cnt_dn_d;
    logic [CW-1:0] cnt_rd_q, cnt_rd_d;
    logic          ovf_q, ovf_d;
    logic          sign_q, sign_d;
    logic [31:0]   aperture_q, aperture_d;
    logic [15:0]   timer_q, timer_d;
    logic [31:0]   apt_dec;
    logic          cyc_start;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    sync2 #(.RST_VAL(1'b0)) u_cmpr_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (cmpr_in),
        .q_o    (cmpr)
    );

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        refmux_d   = refmux_q;
        cnt_up_d   = cnt_up_q;
        cnt_dn_d   = cnt_dn_q;
        cnt_rd_d   = cnt_rd_q;
        ovf_d      = ovf_q;
        sign_d     = sign_q;
        aperture_d = aperture_q;
        timer_d    = timer_q;
        cyc_start  = 1'b0;
        apt_dec    = (aperture_q == '0) ? '0 : aperture_q - 32'd1;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RESET_INT: begin
                if (timer_q == RST_LAST) begin
                    state_d   = ST_RUNUP;
                    timer_d   = '0;
                    cyc_start = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_RUNUP: begin
                aperture_d = apt_dec;
                if (timer_q == CYC_LAST) begin
                    timer_d = '0;
                    // Aperture is rounded up to a whole number of cycles
                    if (apt_dec == '0) begin
                        state_d  = ST_RUNDOWN;
                        sign_d   = cmpr;
                        refmux_d = cmpr ? REFMUX_NEG : REFMUX_POS;
                    end else begin
                        cyc_start = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_RUNDOWN: begin
                if (cmpr != sign_q) begin
                    state_d  = ST_DONE;
                    refmux_d = REFMUX_OFF;
                end else if (cnt_rd_q >= RD_LAST) begin
                    cnt_rd_d = RD_MAX;
                    ovf_d    = 1'b1;
                    state_d  = ST_DONE;
                    refmux_d = REFMUX_OFF;
                end else begin
                    cnt_rd_d = cnt_rd_q + 1'b1;
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                refmux_d = REFMUX_OFF;
            end
        endcase

        if (cyc_start) begin
            refmux_d = cmpr ? REFMUX_NEG : REFMUX_POS;
            if (cmpr) cnt_dn_d = sat_inc(cnt_dn_q);
            else      cnt_up_d = sat_inc(cnt_up_q);
        end

        // A trigger restarts from any state and hides stale results
        if (adc_measure_trig) begin
            state_d    = ST_RESET_INT;
            valid_d    = 1'b0;
            refmux_d   = REFMUX_OFF;
            cnt_up_d   = '0;
            cnt_dn_d   = '0;
            cnt_rd_d   = '0;
            ovf_d      = 1'b0;
            aperture_d = clk_count_aperture_n;
            timer_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            refmux_q   <= REFMUX_OFF;
            cnt_up_q   <= '0;
            cnt_dn_q   <= '0;
            cnt_rd_q   <= '0;
            ovf_q      <= 1'b0;
            sign_q     <= 1'b0;
            aperture_q <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            refmux_q   <= refmux_d;
            cnt_up_q   <= cnt_up_d;
            cnt_dn_q   <= cnt_dn_d;
            cnt_rd_q   <= cnt_rd_d;
            ovf_q      <= ovf_d;
            sign_q     <= sign_d;
            aperture_q <= aperture_d;
            timer_q    <= timer_d;
        end
    end

    assign adc_measure_valid = valid_q;
    assign refmux            = refmux_q;
    assign count_up          = cnt_up_q;
    assign count_down        = cnt_dn_q;
    assign count_rundown     = cnt_rd_q;
    assign overflow          = ovf_q;
    assign sw_int_reset      = (state_q == ST_RUNUP || state_q == ST_RUNDOWN)
                               ? SW_INT_RESET_OPEN : SW_INT_RESET_CLOSED;
    assign monitor           = {state_q == ST_DONE, state_q == ST_RUNUP};

endmodule

// File: tb/tb_adc_multislope.sv
// Directed bench for adc_multislope with a per-clock comparator model.
// Expected timings are derived by hand from the sequencer timing.
module tb_adc_multislope;

    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          adc_measure_trig = 1'b0;
    logic [31:0]   clk_count_aperture_n = '0;
    logic          cmpr_in = 1'b0;
    logic          adc_measure_valid;
    logic          sw_int_reset;
    logic [1:0]    refmux;
    logic [CW-1:0] count_up;
    logic [CW-1:0] count_down;
    logic [CW-1:0] count_rundown;
    logic          overflow;
    logic [1:0]    monitor;

    int checks = 0;
    int errors = 0;

    adc_multislope #(
        .INT_RESET_N (200),
        .CYCLE_N     (100),
        .RUNDOWN_MAX (4000),
        .CW          (CW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .adc_measure_trig     (adc_measure_trig),
        .clk_count_aperture_n (clk_count_aperture_n),
        .cmpr_in              (cmpr_in),
        .adc_measure_valid    (adc_measure_valid),
        .sw_int_reset         (sw_int_reset),
        .refmux               (refmux),
        .count_up             (count_up),
        .count_down           (count_down),
        .count_rundown        (count_rundown),
        .overflow             (overflow),
        .monitor              (monitor)
    );

    always #25 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("mux_not11", 32'(refmux == 2'b11), 0);
            check("sw_mux_excl", 32'(sw_int_reset && refmux != 2'b00), 0);
        end
    end

    // mode 0: cmpr low, 1: cmpr high, 2: alternates every run-up cycle
    function automatic logic cmpr_model(input int mode, input int k);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        if (k < 150) return 1'b0;
        return (((k - 150) / 100) % 2) == 1;
    endfunction

    int done_k, first_ru, mon1_k, pre_sum;
    logic [1:0] r200, r300;

    task automatic run_conv(input logic [31:0] apt, input int mode,
                            input int rk, input int limit);
        int k;
        bit restarted;
        restarted = 0;
        done_k = -1; first_ru = -1; mon1_k = -1; pre_sum = -1;
        r200 = 2'b11; r300 = 2'b11;
        @(negedge clk);
        adc_measure_trig = 1'b1;
        clk_count_aperture_n = apt;
        cmpr_in = cmpr_model(mode, 0);
        @(posedge clk);
        k = 0;
        while (k <= limit) begin
            @(negedge clk);
            adc_measure_trig = 1'b0;
            if (k == 0) begin
                check("valid_drop", 32'(adc_measure_valid), 0);
                check("up_clr", 32'(count_up), 0);
                check("dn_clr", 32'(count_down), 0);
                check("rd_clr", 32'(count_rundown), 0);
                check("ovf_clr", 32'(overflow), 0);
            end
            cmpr_in = cmpr_model(mode, k);
            if (monitor[0] && first_ru < 0) first_ru = k;
            if (monitor[1]) mon1_k = k;
            if (k == 200) r200 = refmux;
            if (k == 300) r300 = refmux;
            if (adc_measure_valid) begin
                done_k = k;
                break;
            end
            if (!restarted && k == rk) begin
                pre_sum = 32'(count_up) + 32'(count_down);
                adc_measure_trig = 1'b1;
                restarted = 1;
                first_ru = -1;
                k = -1;
            end
            @(posedge clk);
            k++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(adc_measure_valid), 0);
        check("rst_sw", 32'(sw_int_reset), 1);
        check("rst_mux", 32'(refmux), 0);
        check("rst_cnts", 32'(count_up | count_down | count_rundown), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_mon", 32'(monitor), 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_valid", 32'(adc_measure_valid), 0);
        check("idle_sw", 32'(sw_int_reset), 1);

        // alternating comparator, aperture 1000
        run_conv(1000, 2, -1, 6000);
        check("alt_first_ru", first_ru, 200);
        check("alt_r200", 32'(r200), 1);
        check("alt_r300", 32'(r300), 2);
        check("alt_up", 32'(count_up), 5);
        check("alt_dn", 32'(count_down), 5);
        check("alt_rd", 32'(count_rundown), 52);
        check("alt_ovf", 32'(overflow), 0);
        check("alt_mon1", mon1_k, 1253);
        check("alt_done_k", done_k, 1254);
        repeat (5) @(negedge clk);
        check("alt_hold", 32'(adc_measure_valid), 1);
        check("alt_idle_sw", 32'(sw_int_reset), 1);

        // comparator stuck high: run-down timeout
        run_conv(1000, 1, -1, 8000);
        check("hi_up", 32'(count_up), 0);
        check("hi_dn", 32'(count_down), 10);
        check("hi_rd", 32'(count_rundown), 4000);
        check("hi_ovf", 32'(overflow), 1);
        check("hi_done_k", done_k, 5201);

        // retrigger inside run-up cycle 4
        run_conv(1000, 2, 550, 6000);
        check("rs_pre_sum", pre_sum, 4);
        check("rs_first_ru", first_ru, 200);
        check("rs_up", 32'(count_up), 5);
        check("rs_dn", 32'(count_down), 5);
        check("rs_rd", 32'(count_rundown), 52);
        check("rs_done_k", done_k, 1254);

        // zero aperture: one cycle
        run_conv(0, 0, -1, 8000);
        check("a0_sum", 32'(count_up) + 32'(count_down), 1);
        check("a0_up", 32'(count_up), 1);
        check("a0_ovf", 32'(overflow), 1);
        check("a0_done_k", done_k, 4301);

        // aperture 1001 rounds up to 11 cycles
        run_conv(1001, 0, -1, 8000);
        check("a1001_up", 32'(count_up), 11);
        check("a1001_dn", 32'(count_down), 0);
        check("a1001_done_k", done_k, 5301);

        // asynchronous reset in the middle of run-up
        @(negedge clk);
        adc_measure_trig = 1'b1;
        clk_count_aperture_n = 1000;
        @(negedge clk);
        adc_measure_trig = 1'b0;
        repeat (400) @(negedge clk);
        check("mid_runup", 32'(monitor), 1);
        reset = 1'b0;
        #1;
        check("ar_mux", 32'(refmux), 0);
        check("ar_sw", 32'(sw_int_reset), 1);
        check("ar_valid", 32'(adc_measure_valid), 0);
        check("ar_cnts", 32'(count_up | count_down | count_rundown), 0);
        @(posedge clk);
        @(negedge clk);
        check("ar_mon", 32'(monitor), 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_valid", 32'(adc_measure_valid), 0);
        check("post_sw", 32'(sw_int_reset), 1);
        check("post_mux", 32'(refmux), 0);
        check("post_mon", 32'(monitor), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_multislope.md
Name: adc_multislope

Overview:
- Multi-slope integrating ADC sequencer; sits directly downstream of the modulation/AZ sequencer.
- Consumes `adc_measure_trig` and returns `adc_measure_valid`, plus run-up and run-down counts, to the modulation block and the MCU readout.
- Drives the integrator reset switch and the reference mux, and samples the integrator comparator.

Parameters:
- INT_RESET_N, 200: clocks the integrator reset switch is held closed before run-up (10us at 20MHz).
- CYCLE_N, 100: clocks per run-up modulation cycle.
- RUNDOWN_MAX, 4000: run-down timeout in clocks; overflow is flagged when it is exceeded.
- CW, 24: width of the result counters.

Ports:
- clk  in  1  system clock, 20MHz.
- reset  in  1  asynchronous, active-low reset.
- adc_measure_trig  in  1  single-clock start pulse from the modulation block.
- clk_count_aperture_n  in  32  integration aperture in clocks; sampled on trig.
- cmpr_in  in  1  integrator comparator output; asynchronous; 1 = integrator positive.
- adc_measure_valid  out  1  high when results are stable and the block is idle.
- sw_int_reset  out  1  1 = integrator reset switch closed.
- refmux  out  2  00 = off, 01 = +ref, 10 = -ref; 11 is never driven.
- count_up  out  CW  run-up cycles with +ref applied.
- count_down  out  CW  run-up cycles with -ref applied.
- count_rundown  out  CW  run-down clocks.
- overflow  out  1  run-down timeout occurred in the last conversion.
- monitor  out  2  debug: [0] high during run-up; [1] one-clock pulse at result latch.

Behaviour:
- Reset (reset low) forces:
  - state = IDLE, adc_measure_valid = 0, sw_int_reset = 1, refmux = 00;
  - all counts = 0, overflow = 0, monitor = 00.
- After reset releases, the block stays in IDLE with valid = 0 until the first conversion completes.
- cmpr_in passes through a 2-flop synchroniser. All references to "cmpr" below mean the synchronised value (2-clock latency).
- Trig handshake:
  - On any edge that samples adc_measure_trig = 1, in any state, the next state is RESET_INT.
  - On that same edge: adc_measure_valid <= 0, aperture latched, count_up/count_down/count_rundown cleared, overflow cleared.
  - A trig mid-conversion aborts and restarts the conversion; no partial result is published.
  - Valid goes low on the same edge that samples trig, so the upstream check `!trig && valid` cannot pass on stale data.
- RESET_INT:
  - sw_int_reset = 1, refmux = 00, for INT_RESET_N clocks.
  - Then go to RUNUP with sw_int_reset = 0.
- RUNUP:
  - The aperture down-counter decrements every clock.
  - At each cycle start, cmpr is sampled:
    - cmpr = 1: refmux = 10 (-ref) for the whole cycle; count_down += 1.
    - cmpr = 0: refmux = 01 (+ref) for the whole cycle; count_up += 1.
  - Each cycle lasts CYCLE_N clocks.
  - Run-up ends only at a cycle boundary where the aperture counter has reached 0. The aperture is therefore rounded up to whole cycles.
  - Aperture = 0 still runs exactly one cycle.
  - monitor[0] = 1 throughout RUNUP.
- RUNDOWN:
  - Sign is sampled on entry: cmpr = 1 gives refmux = 10; cmpr = 0 gives refmux = 01.
  - count_rundown increments each clock.
  - Exit when cmpr differs from the sign sampled on entry (zero-crossing), or when count_rundown reaches RUNDOWN_MAX.
  - On timeout, overflow = 1 and count_rundown holds at RUNDOWN_MAX.
- DONE (1 clock):
  - refmux = 00, sw_int_reset = 1, monitor[1] pulses, adc_measure_valid <= 1, then return to IDLE.
- IDLE:
  - sw_int_reset = 1, refmux = 00.
  - valid and results are held until the next trig.
- Invariants:
  - refmux transitions always go through the cycle boundary logic, never glitch.
  - refmux is never 11.
  - sw_int_reset and refmux != 00 are never asserted together.
- Counter width rules:
  - count_up and count_down saturate at 2^CW-1 (no wrap).
  - count_up + count_down equals the number of run-up cycles.
- Simultaneous events: trig wins over DONE and over the rundown exit; the conversion restarts.

Decomposition:
- Shared package/header `dmm_defs`:
  - REFMUX_OFF, REFMUX_POS, REFMUX_NEG encodings;
  - SW_INT_RESET_CLOSED/OPEN;
  - CLK_FREQ;
  - state encodings.
  The modulation block and the MCU code use the same values.
- One sub-module: `sync2`, a 2-flop synchroniser used for cmpr_in. It is reusable for other asynchronous inputs.

Test Plan:
- Reset low mid-RUNUP → next clock: refmux = 00, sw_int_reset = 1, valid = 0, counts = 0. After release, stays IDLE with valid = 0.
- Aperture = 1000, cmpr model alternating each cycle → 10 cycles: count_up = 5, count_down = 5. Valid rises 1 clock after rundown exit.
- Trig pulse → valid = 0 on the same sampling edge; modulation-block model does not advance until DONE.
- cmpr held at 1 for the entire run → rundown times out: count_rundown = 4000, overflow = 1, valid = 1.
- Second trig during RUNUP (cycle 4) → conversion restarts: counts cleared, RESET_INT lasts 200 clocks, single valid rise at the end.
- Aperture = 0 → exactly one run-up cycle: count_up + count_down = 1. Assertions on every clock: refmux != 11, and never (sw_int_reset && refmux != 00).
